// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: datapath width and memory access sizes.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_BYTE_U = 3'd1,
    MEM_HALF   = 3'd2,
    MEM_HALF_U = 3'd3,
    MEM_WORD   = 3'd4
  } mem_op_e;
endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake and dmem port bundle for the load/store unit.
interface lsu_ctrl_if;
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_is_store;
  logic [riscv_pkg::XLEN-1:0]    req_addr;
  logic [riscv_pkg::XLEN-1:0]    req_wdata;
  riscv_pkg::mem_op_e            req_op;
  logic                          resp_valid;
  logic [riscv_pkg::XLEN-1:0]    resp_rdata;
  logic                          resp_split;
  logic [riscv_pkg::XLEN-1:0]    dmem_addr;
  logic [riscv_pkg::XLEN-1:0]    dmem_wdata;
  logic                          dmem_wr_en;
  logic                          dmem_rd_en;
  riscv_pkg::mem_op_e            dmem_mem_op;
  logic [riscv_pkg::XLEN-1:0]    dmem_rdata;

  // Execute stage and memory side: issues requests, returns read data.
  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_op, dmem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_split,
    input  dmem_addr, dmem_wdata, dmem_wr_en, dmem_rd_en, dmem_mem_op
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_op, dmem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_split,
    output dmem_addr, dmem_wdata, dmem_wr_en, dmem_rd_en, dmem_mem_op
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator: aligned accesses go to dmem in one cycle, misaligned
// half/word accesses are broken into byte accesses and reassembled
// little-endian before a single-cycle response pulse.
module lsu_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_asm;
  logic [XLEN-1:0] r_rdata;
  mem_op_e         r_op;
  logic            r_store;
  logic            r_split_done;
  logic [1:0]      r_cnt;

  logic            w_accept;
  logic            w_split;
  logic [1:0]      w_last_idx;
  logic            w_last;
  logic [7:0]      w_wbyte;
  logic [XLEN-1:0] w_asm;
  logic [XLEN-1:0] w_result;

  assign w_accept = (r_state == IDLE) && !reset && bus.req_valid;
  assign w_last   = (r_cnt == w_last_idx);
  assign w_wbyte  = 8'(r_wdata >> {r_cnt, 3'b000});

  // Classify the latched request: split or not, and index of the last byte.
  always_comb begin
    w_split    = 1'b0;
    w_last_idx = 2'd0;
    case (r_op)
      MEM_HALF, MEM_HALF_U: begin
        w_split    = r_addr[0];
        w_last_idx = {1'b0, r_addr[0]};
      end
      MEM_WORD: begin
        w_split    = (r_addr[1:0] != 2'b00);
        w_last_idx = w_split ? 2'd3 : 2'd0;
      end
      default: ;
    endcase
  end

  // Merge this cycle's byte into the assembly and form the final load result.
  always_comb begin
    w_asm = r_asm;
    w_asm[{r_cnt, 3'b000} +: 8] = bus.dmem_rdata[7:0];
    w_result = '0;
    if (!r_store) begin
      if (!w_split) begin
        w_result = bus.dmem_rdata;
      end else begin
        case (r_op)
          MEM_HALF:   w_result = {{(XLEN-16){w_asm[15]}}, w_asm[15:0]};
          MEM_HALF_U: w_result = {{(XLEN-16){1'b0}}, w_asm[15:0]};
          default:    w_result = w_asm;
        endcase
      end
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus all handshake and dmem outputs; dmem is idle unless in ACCESS.
  always_comb begin
    w_state_next    = r_state;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = '0;
    bus.resp_split  = 1'b0;
    bus.dmem_addr   = '0;
    bus.dmem_wdata  = '0;
    bus.dmem_wr_en  = 1'b0;
    bus.dmem_rd_en  = 1'b0;
    bus.dmem_mem_op = MEM_WORD;
    case (r_state)
      IDLE: begin
        bus.req_ready = !reset;
        if (w_accept) w_state_next = ACCESS;
      end
      ACCESS: begin
        bus.dmem_wr_en = r_store;
        bus.dmem_rd_en = !r_store;
        if (w_split) begin
          bus.dmem_addr   = r_addr + XLEN'(r_cnt);
          bus.dmem_wdata  = {{(XLEN-8){1'b0}}, w_wbyte};
          bus.dmem_mem_op = r_store ? MEM_BYTE : MEM_BYTE_U;
        end else begin
          bus.dmem_addr   = r_addr;
          bus.dmem_wdata  = r_wdata;
          bus.dmem_mem_op = r_op;
        end
        if (w_last) w_state_next = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = r_rdata;
        bus.resp_split = r_split_done;
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch, byte counter and load-data assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_op         <= MEM_WORD;
      r_store      <= 1'b0;
      r_cnt        <= 2'd0;
      r_asm        <= '0;
      r_rdata      <= '0;
      r_split_done <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_op    <= bus.req_op;
      r_store <= bus.req_is_store;
      r_cnt   <= 2'd0;
      r_asm   <= '0;
    end else if (r_state == ACCESS) begin
      r_asm <= w_asm;
      r_cnt <= r_cnt + 2'd1;
      if (w_last) begin
        r_rdata      <= w_result;
        r_split_done <= w_split;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed dmem model.
module tb_lsu_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();

  lsu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // 256-byte memory, address taken modulo 256 so wrapped addresses alias.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] a0;
  logic [7:0] m0, m1, m2, m3;
  assign a0 = bus.dmem_addr[7:0];
  assign m0 = mem[a0];
  assign m1 = mem[a0 + 8'd1];
  assign m2 = mem[a0 + 8'd2];
  assign m3 = mem[a0 + 8'd3];

  // Combinational read port with per-op extension.
  always_comb begin
    bus.dmem_rdata = {m3, m2, m1, m0};
    case (bus.dmem_mem_op)
      MEM_BYTE:   bus.dmem_rdata = {{24{m0[7]}}, m0};
      MEM_BYTE_U: bus.dmem_rdata = {24'h0, m0};
      MEM_HALF:   bus.dmem_rdata = {{16{m1[7]}}, m1, m0};
      MEM_HALF_U: bus.dmem_rdata = {16'h0, m1, m0};
      default:    bus.dmem_rdata = {m3, m2, m1, m0};
    endcase
  end

  // Stores commit at the rising edge.
  always @(posedge clk) begin
    if (bus.dmem_wr_en) begin
      mem[a0] <= bus.dmem_wdata[7:0];
      if (bus.dmem_mem_op == MEM_HALF || bus.dmem_mem_op == MEM_HALF_U ||
          bus.dmem_mem_op == MEM_WORD)
        mem[a0 + 8'd1] <= bus.dmem_wdata[15:8];
      if (bus.dmem_mem_op == MEM_WORD) begin
        mem[a0 + 8'd2] <= bus.dmem_wdata[23:16];
        mem[a0 + 8'd3] <= bus.dmem_wdata[31:24];
      end
    end
  end

  // Strobe log, sampled mid-cycle.
  logic [31:0] log_addr [256];
  logic [31:0] log_wd   [256];
  int log_n       = 0;
  int overlap_cnt = 0;
  int resp_cnt    = 0;
  always @(negedge clk) begin
    if (bus.dmem_rd_en || bus.dmem_wr_en) begin
      log_addr[log_n % 256] = bus.dmem_addr;
      log_wd[log_n % 256]   = bus.dmem_wdata;
      log_n++;
    end
    if (bus.dmem_rd_en && bus.dmem_wr_en) overlap_cnt++;
    if (bus.resp_valid) resp_cnt++;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int xbase;

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_vec({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic xact(input string tag, input logic st, input logic [31:0] a,
                      input logic [31:0] wd, input mem_op_e op,
                      input logic [31:0] exp_rd, input logic exp_sp, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_op       = op;
    wait_ready(tag);
    xbase = log_n;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = ~st;
    bus.req_addr     = 32'hDEAD_BEEF;
    bus.req_wdata    = 32'hFFFF_FFFF;
    bus.req_op       = MEM_BYTE;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_vec({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check_vec({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    check_vec({tag, "_split"}, 32'(bus.resp_split), 32'(exp_sp));
    $display("xact %s st=%0d addr=%08h op=%0d rdata=%08h split=%0d lat=%0d",
             tag, st, a, op, bus.resp_rdata, bus.resp_split, lat);
    @(posedge clk); #1;
    check_vec({tag, "_pulse"},   32'(bus.resp_valid), 32'd0);
    check_vec({tag, "_strobes"}, 32'(log_n - xbase), 32'(exp_lat - 1));
  endtask

  logic [31:0] exp_a [4];
  logic [7:0]  exp_b [4];
  int rbase;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_op       = MEM_WORD;

    // Reset values.
    #2;
    check_vec("rst_ready",  32'(bus.req_ready), 32'd0);
    check_vec("rst_resp",   32'(bus.resp_valid), 32'd0);
    check_vec("rst_rdata",  bus.resp_rdata, 32'd0);
    check_vec("rst_split",  32'(bus.resp_split), 32'd0);
    check_vec("rst_addr",   bus.dmem_addr, 32'd0);
    check_vec("rst_op",     32'(bus.dmem_mem_op), 32'(MEM_WORD));
    check_vec("rst_strobe", 32'({bus.dmem_rd_en, bus.dmem_wr_en}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_vec("rel_ready", 32'(bus.req_ready), 32'd1);

    // Aligned word.
    xact("st_w_al", 1'b1, 32'h00, 32'h1234_5678, MEM_WORD, 32'h0, 1'b0, 2);
    xact("ld_w_al", 1'b0, 32'h00, 32'h0, MEM_WORD, 32'h1234_5678, 1'b0, 2);

    // Misaligned word.
    xact("st_w_mis", 1'b1, 32'h05, 32'hA1B2_C3D4, MEM_WORD, 32'h0, 1'b1, 5);
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("st_w_mis_a%0d", i), log_addr[(xbase + i) % 256], 32'h05 + 32'(i));
      check_vec($sformatf("st_w_mis_d%0d", i), log_wd[(xbase + i) % 256], {24'h0, exp_b[i]});
    end
    xact("ld_w_mis", 1'b0, 32'h05, 32'h0, MEM_WORD, 32'hA1B2_C3D4, 1'b1, 5);

    // Misaligned half sign handling.
    xact("st_h_mis",  1'b1, 32'h21, 32'h0000_8001, MEM_HALF,   32'h0, 1'b1, 3);
    xact("ld_h_mis",  1'b0, 32'h21, 32'h0, MEM_HALF,   32'hFFFF_8001, 1'b1, 3);
    xact("ld_hu_mis", 1'b0, 32'h21, 32'h0, MEM_HALF_U, 32'h0000_8001, 1'b1, 3);
    xact("ld_bu_22",  1'b0, 32'h22, 32'h0, MEM_BYTE_U, 32'h0000_0080, 1'b0, 2);

    // Byte ops at every offset.
    for (int k = 0; k < 4; k++) begin
      xact($sformatf("st_b%0d", k),  1'b1, 32'h10 + 32'(k), 32'h0000_00A5, MEM_BYTE,   32'h0, 1'b0, 2);
      xact($sformatf("ld_b%0d", k),  1'b0, 32'h10 + 32'(k), 32'h0, MEM_BYTE,   32'hFFFF_FFA5, 1'b0, 2);
      xact($sformatf("ld_bu%0d", k), 1'b0, 32'h10 + 32'(k), 32'h0, MEM_BYTE_U, 32'h0000_00A5, 1'b0, 2);
    end

    // Reset during the second byte of a split word store.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_addr     = 32'h41;
    bus.req_wdata    = 32'h1122_3344;
    bus.req_op       = MEM_WORD;
    wait_ready("rst_mid");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check_vec("rst_mid_b1_addr", bus.dmem_addr, 32'h42);
    rbase = resp_cnt;
    reset = 1'b1;
    #1;
    check_vec("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    check_vec("rst_mid_wr",    32'(bus.dmem_wr_en), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_vec("rst_mid_noresp", 32'(resp_cnt - rbase), 32'd0);
    check_vec("rst_mid_m41", 32'(mem[8'h41]), 32'h44);
    check_vec("rst_mid_m42", 32'(mem[8'h42]), 32'h00);
    check_vec("rst_mid_m43", 32'(mem[8'h43]), 32'h00);
    check_vec("rst_mid_m44", 32'(mem[8'h44]), 32'h00);
    check_vec("rst_mid_rel_ready", 32'(bus.req_ready), 32'd1);
    $display("xact rst_mid st=1 addr=00000041 aborted after first byte");

    // Back-to-back with req_valid held high.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_addr     = 32'h30;
    bus.req_wdata    = 32'hCAFE_F00D;
    bus.req_op       = MEM_WORD;
    wait_ready("b2b");
    @(posedge clk); #1;
    bus.req_is_store = 1'b0;
    bus.req_wdata    = 32'h0;
    @(posedge clk); #1;
    check_vec("b2b_resp1",    32'(bus.resp_valid), 32'd1);
    check_vec("b2b_rdy_resp", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    check_vec("b2b_rdy_idle",   32'(bus.req_ready), 32'd1);
    check_vec("b2b_idle_quiet", 32'({bus.dmem_rd_en, bus.dmem_wr_en}), 32'd0);
    @(posedge clk); #1;
    check_vec("b2b_acc2_rd",   32'(bus.dmem_rd_en), 32'd1);
    check_vec("b2b_acc2_addr", bus.dmem_addr, 32'h30);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check_vec("b2b_resp2",  32'(bus.resp_valid), 32'd1);
    check_vec("b2b_rdata2", bus.resp_rdata, 32'hCAFE_F00D);
    $display("xact b2b second load rdata=%08h", bus.resp_rdata);
    @(posedge clk); #1;

    // Address wrap on a split word.
    xact("st_w_wrap", 1'b1, 32'hFFFF_FFFE, 32'h5566_7788, MEM_WORD, 32'h0, 1'b1, 5);
    exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++)
      check_vec($sformatf("wrap_a%0d", i), log_addr[(xbase + i) % 256], exp_a[i]);
    xact("ld_w_wrap", 1'b0, 32'hFFFF_FFFE, 32'h0, MEM_WORD, 32'h5566_7788, 1'b1, 5);

    check_vec("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
